// File: rtl/uart_rx.sv
// UART receiver: start, DATA_BITS data bits LSB first, stop bit, with a one-cycle result strobe
// one cycle after the stop-bit mid-sample. Optional even parity bit when UART_RX_PARITY_EN is defined.
module uart_rx #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 framing_error,
    output logic                 parity_error,
    output logic                 busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd5;
`endif

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q;
    logic                 vld_pend_q, vld_pend_d;
    logic                 fe_pend_q, fe_pend_d;
    logic                 data_valid_q, framing_error_q;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 pe_pend_q, pe_pend_d;
    logic                 parity_error_q;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        vld_pend_d = 1'b0;
        fe_pend_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d      = par_q;
        pe_pend_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!serial_in) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = serial_in ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = serial_in;
                    idx_d          = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    par_d   = serial_in;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                // Leaving mid stop bit lets a directly following start bit be seen.
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (serial_in) begin
                        state_d    = S_IDLE;
                        vld_pend_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        if (^{shift_q, par_q}) begin
                            vld_pend_d = 1'b0;
                            pe_pend_d  = 1'b1;
                        end
`endif
                    end else begin
                        state_d   = S_BREAK;
                        fe_pend_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BREAK: begin
                if (serial_in) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            idx_q           <= '0;
            shift_q         <= '0;
            data_q          <= '0;
            vld_pend_q      <= 1'b0;
            fe_pend_q       <= 1'b0;
            data_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            shift_q         <= shift_d;
            vld_pend_q      <= vld_pend_d;
            fe_pend_q       <= fe_pend_d;
            data_valid_q    <= vld_pend_q;
            framing_error_q <= fe_pend_q;
            if (vld_pend_q) data_q <= shift_q;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            par_q          <= 1'b0;
            pe_pend_q      <= 1'b0;
            parity_error_q <= 1'b0;
        end else begin
            par_q          <= par_d;
            pe_pend_q      <= pe_pend_d;
            parity_error_q <= pe_pend_q;
        end
    end
    assign parity_error = parity_error_q;
`else
    assign parity_error = 1'b0;
`endif

    assign data_out      = data_q;
    assign data_valid    = data_valid_q;
    assign framing_error = framing_error_q;
    assign busy          = (state_q != S_IDLE);
endmodule
